// File: rtl/dram_sched_pkg.sv
// rtl/dram_sched_pkg.sv - shared sizing constants and request entry type for the DRAM request scheduler
package dram_sched_pkg;

   localparam int FIFO_DEPTH = 16;
   localparam int MAX_OUT    = 32;
   localparam int ADDR_W     = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr_k;
      logic [ADDR_W-1:0] addr_l;
   } entry_t;

endpackage

// File: rtl/sched_fifo.sv
// rtl/sched_fifo.sv - request buffer FIFO with synchronous clear and full/empty/count status
module sched_fifo
   import dram_sched_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clr_i,
   input  logic                         wr_en_i,
   input  entry_t                       wr_data_i,
   input  logic                         rd_en_i,
   output entry_t                       rd_data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;

   // Storage is not reset; only pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en_i) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (rd_en_i) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (wr_en_i && !rd_en_i) begin
            count_q <= count_q + CW'(1);
         end else if (rd_en_i && !wr_en_i) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;

endmodule

// File: rtl/dram_req_scheduler.sv
// rtl/dram_req_scheduler.sv - buffers datapath DRAM requests and issues them under an outstanding-request credit limit
module dram_req_scheduler #(
   parameter int FIFO_DEPTH = dram_sched_pkg::FIFO_DEPTH,
   parameter int MAX_OUT    = dram_sched_pkg::MAX_OUT
) (
   input  logic                               Clk_32UI,
   input  logic                               reset_BWT_extend,
   input  logic                               req_valid,
   input  logic [dram_sched_pkg::ADDR_W-1:0]  req_addr_k,
   input  logic [dram_sched_pkg::ADDR_W-1:0]  req_addr_l,
   output logic                               req_ready,
   input  logic                               flush,
   output logic                               mem_valid,
   output logic [dram_sched_pkg::ADDR_W-1:0]  mem_addr_k,
   output logic [dram_sched_pkg::ADDR_W-1:0]  mem_addr_l,
   input  logic                               mem_ready,
   input  logic                               rsp_valid,
   output logic [5:0]                         outstanding,
   output logic [15:0]                        drop_cnt,
   output logic                               rsp_err,
   output logic                               idle
);

   import dram_sched_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   entry_t          req_entry;
   entry_t          fifo_head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;

   logic            mem_valid_q, mem_valid_d;
   entry_t          stage_q, stage_d;
   logic [5:0]      outstanding_q, outstanding_d;
   logic [15:0]     drop_cnt_q, drop_cnt_d;
   logic            rsp_err_q, rsp_err_d;

   logic [6:0]      in_use;
   logic            issue;
   logic            can_load;
   logic            pop;
   logic            bypass;
   logic            take;
   logic            push;
   logic            drop;

   assign req_entry = '{addr_k: req_addr_k, addr_l: req_addr_l};

   always_comb begin
      in_use   = {1'b0, outstanding_q} + {6'd0, mem_valid_q};
      // The handshake only counts below MAX_OUT; otherwise the loaded entry waits for a response.
      issue    = mem_valid_q && mem_ready && (outstanding_q < 6'(MAX_OUT));
      can_load = (!mem_valid_q || issue) &&
                 ((in_use < 7'(MAX_OUT)) || ((in_use == 7'(MAX_OUT)) && issue));
      take     = req_valid && !flush;
      pop      = can_load && !fifo_empty && !flush;
      bypass   = can_load && fifo_empty && take;
      push     = take && !bypass && (!fifo_full || pop);
      drop     = take && !bypass && fifo_full && !pop;
   end

   always_comb begin
      mem_valid_d   = mem_valid_q;
      stage_d       = stage_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      rsp_err_d     = rsp_err_q;

      if (pop) begin
         mem_valid_d = 1'b1;
         stage_d     = fifo_head;
      end else if (bypass) begin
         mem_valid_d = 1'b1;
         stage_d     = req_entry;
      end else if (issue) begin
         mem_valid_d = 1'b0;
      end

      if (issue && !rsp_valid) begin
         outstanding_d = outstanding_q + 6'd1;
      end else if (rsp_valid && !issue) begin
         if (outstanding_q != '0) begin
            outstanding_d = outstanding_q - 6'd1;
         end else begin
            rsp_err_d = 1'b1;
         end
      end

      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge Clk_32UI or posedge reset_BWT_extend) begin
      if (reset_BWT_extend) begin
         mem_valid_q   <= 1'b0;
         stage_q       <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         rsp_err_q     <= 1'b0;
      end else begin
         mem_valid_q   <= mem_valid_d;
         stage_q       <= stage_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         rsp_err_q     <= rsp_err_d;
      end
   end

   sched_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (Clk_32UI),
      .rst_i     (reset_BWT_extend),
      .clr_i     (flush),
      .wr_en_i   (push),
      .wr_data_i (req_entry),
      .rd_en_i   (pop),
      .rd_data_o (fifo_head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   assign req_ready   = (fifo_count != CW'(FIFO_DEPTH));
   assign mem_valid   = mem_valid_q;
   assign mem_addr_k  = stage_q.addr_k;
   assign mem_addr_l  = stage_q.addr_l;
   assign outstanding = outstanding_q;
   assign drop_cnt    = drop_cnt_q;
   assign rsp_err     = rsp_err_q;
   assign idle        = fifo_empty && !mem_valid_q && (outstanding_q == '0);

endmodule

// File: tb/tb_dram_req_scheduler.sv
// tb/tb_dram_req_scheduler.sv - self-checking bench for dram_req_scheduler
module tb_dram_req_scheduler;

   logic        Clk_32UI = 1'b0;
   logic        reset_BWT_extend = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr_k = '0;
   logic [31:0] req_addr_l = '0;
   logic        req_ready;
   logic        flush = 1'b0;
   logic        mem_valid;
   logic [31:0] mem_addr_k;
   logic [31:0] mem_addr_l;
   logic        mem_ready = 1'b0;
   logic        rsp_valid = 1'b0;
   logic [5:0]  outstanding;
   logic [15:0] drop_cnt;
   logic        rsp_err;
   logic        idle;

   always #5 Clk_32UI = ~Clk_32UI;

   dram_req_scheduler dut (
      .Clk_32UI         (Clk_32UI),
      .reset_BWT_extend (reset_BWT_extend),
      .req_valid        (req_valid),
      .req_addr_k       (req_addr_k),
      .req_addr_l       (req_addr_l),
      .req_ready        (req_ready),
      .flush            (flush),
      .mem_valid        (mem_valid),
      .mem_addr_k       (mem_addr_k),
      .mem_addr_l       (mem_addr_l),
      .mem_ready        (mem_ready),
      .rsp_valid        (rsp_valid),
      .outstanding      (outstanding),
      .drop_cnt         (drop_cnt),
      .rsp_err          (rsp_err),
      .idle             (idle)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] sb_q[$];
   int          tb_out  = 0;
   logic        mon_en  = 1'b0;

   typedef struct {
      logic        rv;
      logic [31:0] k;
      logic [31:0] l;
      logic        mr;
      logic        rsp;
      logic        fl;
      logic        e_mv;
      logic [31:0] e_k;
      logic [31:0] e_l;
      logic [5:0]  e_out;
      logic        e_idle;
      logic        e_rdy;
      logic        e_err;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue monitor: every accepted request must match the oldest expected entry.
   always @(negedge Clk_32UI) begin
      logic fire;
      if (mon_en && !reset_BWT_extend) begin
         fire = mem_valid && mem_ready && (tb_out < 32);
         if (fire) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_issue: got k=0x%0h l=0x%0h, expected no issue", mem_addr_k, mem_addr_l);
            end else begin
               check("issue_addr", {mem_addr_k, mem_addr_l}, sb_q.pop_front());
            end
         end
         if (fire && !rsp_valid) tb_out++;
         else if (rsp_valid && !fire && tb_out > 0) tb_out--;
      end
   end

   task automatic step(input logic rv, input logic [31:0] k, input logic [31:0] l,
                       input logic mr, input logic rsp, input logic fl);
      req_valid  = rv;
      req_addr_k = k;
      req_addr_l = l;
      mem_ready  = mr;
      rsp_valid  = rsp;
      flush      = fl;
      @(posedge Clk_32UI);
      #1;
   endtask

   task automatic req(input logic [31:0] k, input logic [31:0] l, input logic mr);
      sb_q.push_back({k, l});
      step(1'b1, k, l, mr, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      req_valid = 1'b0;
      mem_ready = 1'b0;
      rsp_valid = 1'b0;
      flush = 1'b0;
      reset_BWT_extend = 1'b1;
      sb_q.delete();
      tb_out = 0;
      repeat (2) @(posedge Clk_32UI);
      #1;
      reset_BWT_extend = 1'b0;
      mon_en = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h200, 6'd0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 32'h0,   32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   6'd1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 32'h0,   32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   6'd0, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 32'h11,  32'h22,  1'b0, 1'b0, 1'b0, 1'b1, 32'h11,  32'h22,  6'd0, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 32'h33,  32'h44,  1'b0, 1'b0, 1'b0, 1'b1, 32'h11,  32'h22,  6'd0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 32'h0,   32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h33,  32'h44,  6'd1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 32'h0,   32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   6'd1, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   6'd0, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   6'd0, 1'b1, 1'b1, 1'b1};

      // Reset values
      do_reset();
      check("rst_mem_valid", mem_valid, 1'b0);
      check("rst_addr", {mem_addr_k, mem_addr_l}, 64'h0);
      check("rst_outstanding", outstanding, 6'd0);
      check("rst_drop_cnt", drop_cnt, 16'd0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_idle", idle, 1'b1);

      // Table-driven basic flow: bypass, hold, FIFO ordering, response accounting
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].rv) sb_q.push_back({vecs[i].k, vecs[i].l});
         step(vecs[i].rv, vecs[i].k, vecs[i].l, vecs[i].mr, vecs[i].rsp, vecs[i].fl);
         check($sformatf("vec%0d_mem_valid", i), mem_valid, vecs[i].e_mv);
         check($sformatf("vec%0d_outstanding", i), outstanding, vecs[i].e_out);
         check($sformatf("vec%0d_idle", i), idle, vecs[i].e_idle);
         check($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].e_rdy);
         check($sformatf("vec%0d_rsp_err", i), rsp_err, vecs[i].e_err);
         if (vecs[i].e_mv) check($sformatf("vec%0d_addr", i), {mem_addr_k, mem_addr_l}, {vecs[i].e_k, vecs[i].e_l});
      end
      check("vec_sb_empty", sb_q.size(), 0);

      // Full FIFO, drop, and simultaneous read/write while full
      do_reset();
      for (int i = 0; i < 17; i++) req(32'h2000 + 32'(i), 32'h3000 + 32'(i), 1'b0);
      check("full_mem_valid", mem_valid, 1'b1);
      check("full_head_addr", mem_addr_k, 32'h2000);
      check("full_req_ready", req_ready, 1'b0);
      check("full_drop0", drop_cnt, 16'd0);
      step(1'b1, 32'hBAD0, 32'hBAD1, 1'b0, 1'b0, 1'b0);
      check("full_drop1", drop_cnt, 16'd1);
      req(32'hAA, 32'hAB, 1'b1);
      check("full_rw_nodrop", drop_cnt, 16'd1);
      check("full_rw_req_ready", req_ready, 1'b0);
      check("full_rw_addr", mem_addr_k, 32'h2001);
      repeat (20) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("full_drain_sb", sb_q.size(), 0);
      check("full_drain_out", outstanding, 6'd18);
      check("full_drain_mv", mem_valid, 1'b0);
      check("full_drain_ready", req_ready, 1'b1);

      // Credit limit: 32 accepted, 33rd held until a response
      do_reset();
      for (int i = 0; i < 40; i++) req(32'h4000 + 32'(i), 32'h5000 + 32'(i), 1'b1);
      repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("credit_out32", outstanding, 6'd32);
      check("credit_mv_held", mem_valid, 1'b1);
      check("credit_addr33", {mem_addr_k, mem_addr_l}, {32'h4020, 32'h5020});
      check("credit_sb8", sb_q.size(), 8);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("credit_rsp_out31", outstanding, 6'd31);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("credit_reissue_out32", outstanding, 6'd32);
      check("credit_addr34", mem_addr_k, 32'h4021);
      check("credit_sb7", sb_q.size(), 7);

      // Simultaneous issue/response and response underflow
      do_reset();
      req(32'h60, 32'h61, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("same0_out", outstanding, 6'd0);
      check("same0_err", rsp_err, 1'b0);
      for (int i = 0; i < 6; i++) req(32'h7000 + 32'(i), 32'h7100 + 32'(i), 1'b1);
      check("out5_pre", outstanding, 6'd5);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("out5_same_cycle", outstanding, 6'd5);
      check("out5_mv", mem_valid, 1'b0);
      repeat (5) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      check("drain_out0", outstanding, 6'd0);
      check("drain_err0", rsp_err, 1'b0);
      check("drain_idle", idle, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      check("underflow_err", rsp_err, 1'b1);
      check("underflow_out", outstanding, 6'd0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("err_sticky", rsp_err, 1'b1);

      // Flush with 4 buffered entries and a same-cycle request
      do_reset();
      req(32'h8000, 32'h8001, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h8100 + 32'(i), 32'h8200, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b1);
      check("flush_mv_kept", mem_valid, 1'b1);
      check("flush_addr_kept", mem_addr_k, 32'h8000);
      check("flush_ready", req_ready, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("flush_issue_out", outstanding, 6'd1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
         check($sformatf("flush_no_mv%0d", i), mem_valid, 1'b0);
      end
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      check("flush_idle", idle, 1'b1);
      check("flush_drop", drop_cnt, 16'd0);
      check("flush_sb", sb_q.size(), 0);

      // Asynchronous reset mid-burst
      do_reset();
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) req(32'h9000 + 32'(i), 32'h9100, 1'b0);
      step(1'b1, 32'h9999, 32'h9999, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("arst_pre_err", rsp_err, 1'b1);
      check("arst_pre_drop", drop_cnt, 16'd1);
      check("arst_pre_out", outstanding, 6'd3);
      req_valid = 1'b1;
      mem_ready = 1'b1;
      #2;
      mon_en = 1'b0;
      reset_BWT_extend = 1'b1;
      #1;
      check("arst_mem_valid", mem_valid, 1'b0);
      check("arst_addr", {mem_addr_k, mem_addr_l}, 64'h0);
      check("arst_out", outstanding, 6'd0);
      check("arst_drop", drop_cnt, 16'd0);
      check("arst_err", rsp_err, 1'b0);
      check("arst_ready", req_ready, 1'b1);
      check("arst_idle", idle, 1'b1);
      do_reset();
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("post_arst_idle", idle, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
